// File: rtl/wts_for_cartridge.sv
// Cartridge-slot front end of the wave-table-sound card: slot bus decode,
// four-page 8 KB bank mapper, WTS register file with 12 square-wave tone
// channels, two interval timers, open-collector /INT and a 12-bit stereo mix.
module wts_for_cartridge #(
  parameter int TICK_DIV = 16
) (
  input  logic        clk,
  input  logic        slot_reset,
  output logic        slot_nint,
  input  logic [14:0] slot_a,
  inout  logic [7:0]  slot_d,
  input  logic        slot_nsltsl,
  input  logic        slot_nmerq,
  input  logic        slot_nrd,
  input  logic        slot_nwr,
  input  logic        sw_mono,
  output logic        mem_ncs,
  output logic [7:0]  mem_a,
  output logic [11:0] left_out,
  output logic [11:0] right_out
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  // Bus handshake: an access is nsltsl=0 & nmerq=0. A write commits exactly
  // once on the synchronized falling edge of nwr; a status-register read takes
  // effect (flag clear) on the synchronized rising edge of nrd. Address and
  // data must be stable from before the strobe falls until after it rises.

  // ---------------------------------------------------------------- state
  logic [14:0] a_s1_q, a_s2_q;
  logic [7:0]  d_s1_q, d_s2_q;
  logic        nsltsl_s1_q, nsltsl_s2_q;
  logic        nmerq_s1_q, nmerq_s2_q;
  logic        nrd_s1_q, nrd_s2_q, nrd_s3_q;
  logic        nwr_s1_q, nwr_s2_q, nwr_s3_q;

  logic [7:0]  bank_q [4];
  logic        mode6_q;

  logic [11:0] freq_q [12];
  logic [3:0]  vol_q  [12];
  logic [1:0]  en_q   [12];

  logic [7:0]    tctl_q  [2];
  logic [5:0]    tcnt_q  [2];
  logic [PW-1:0] tpre_q  [2];
  logic [1:0]    tflag_q;

  logic [PW-1:0] tone_pre_q;
  logic [11:0]   tone_cnt_q [12];
  logic [11:0]   sq_q;

  logic [11:0] left_q, right_q, left_d, right_d;

  // ------------------------------------------------ combinational decode
  logic       wts_en;
  logic       access;
  logic [1:0] page;
  logic       in_win;
  logic [7:0] rdata;
  logic [3:0] rd_ch;

  assign wts_en = mode6_q & bank_q[3][7];
  assign access = ~slot_nsltsl & ~slot_nmerq;
  assign page   = slot_a[14:13] ^ 2'b10;
  assign in_win = wts_en & (page == 2'd3) & (slot_a[12:11] == 2'b01);
  assign rd_ch  = slot_a[7:4];

  // Register read mux for the live (unsynchronized) address.
  always_comb begin
    rdata = 8'hFF;
    if ((slot_a[7:0] < 8'hC0) && (slot_a[3:2] == 2'b00)) begin
      case (slot_a[1:0])
        2'd0:    rdata = freq_q[rd_ch][7:0];
        2'd1:    rdata = {4'h0, freq_q[rd_ch][11:8]};
        2'd2:    rdata = {4'h0, vol_q[rd_ch]};
        default: rdata = {6'h00, en_q[rd_ch]};
      endcase
    end else begin
      case (slot_a[7:0])
        8'hF0:   rdata = tctl_q[0];
        8'hF1:   rdata = {~tflag_q[0], 7'b0};
        8'hF2:   rdata = tctl_q[1];
        8'hF3:   rdata = {~tflag_q[1], 7'b0};
        default: rdata = 8'hFF;
      endcase
    end
  end

  assign mem_a     = bank_q[page];
  assign mem_ncs   = ~(access & ~slot_nrd & ~in_win);
  assign slot_d    = (~slot_reset & access & ~slot_nrd & in_win) ? rdata : 8'hzz;
  assign slot_nint = (~slot_reset & (tflag_q[0] | tflag_q[1])) ? 1'b0 : 1'bz;

  // ------------------------------------------- synchronized write decode
  logic       acc_s, wr_go, rd_done, w_win, ch_wr;
  logic [1:0] w_page;
  logic [7:0] w_idx;
  logic [3:0] w_ch;
  logic [1:0] tctl_wr, tstat_rd;

  assign acc_s    = ~nsltsl_s2_q & ~nmerq_s2_q;
  assign wr_go    = acc_s & ~nwr_s2_q & nwr_s3_q;
  assign rd_done  = acc_s & nrd_s2_q & ~nrd_s3_q;
  assign w_page   = a_s2_q[14:13] ^ 2'b10;
  assign w_win    = wts_en & (w_page == 2'd3) & (a_s2_q[12:11] == 2'b01);
  assign w_idx    = a_s2_q[7:0];
  assign w_ch     = w_idx[7:4];
  assign ch_wr    = wr_go & w_win & (w_idx < 8'hC0) & (w_idx[3:2] == 2'b00);
  assign tctl_wr  = {wr_go & w_win & (w_idx == 8'hF2), wr_go & w_win & (w_idx == 8'hF0)};
  assign tstat_rd = {rd_done & w_win & (w_idx == 8'hF3), rd_done & w_win & (w_idx == 8'hF1)};

  // Double-flop every bus signal into clk; third stage on strobes for edges.
  always_ff @(posedge clk) begin
    if (slot_reset) begin
      a_s1_q <= '0;  a_s2_q <= '0;
      d_s1_q <= '0;  d_s2_q <= '0;
      nsltsl_s1_q <= 1'b1; nsltsl_s2_q <= 1'b1;
      nmerq_s1_q  <= 1'b1; nmerq_s2_q  <= 1'b1;
      nrd_s1_q <= 1'b1; nrd_s2_q <= 1'b1; nrd_s3_q <= 1'b1;
      nwr_s1_q <= 1'b1; nwr_s2_q <= 1'b1; nwr_s3_q <= 1'b1;
    end else begin
      a_s1_q <= slot_a;       a_s2_q <= a_s1_q;
      d_s1_q <= slot_d;       d_s2_q <= d_s1_q;
      nsltsl_s1_q <= slot_nsltsl; nsltsl_s2_q <= nsltsl_s1_q;
      nmerq_s1_q  <= slot_nmerq;  nmerq_s2_q  <= nmerq_s1_q;
      nrd_s1_q <= slot_nrd; nrd_s2_q <= nrd_s1_q; nrd_s3_q <= nrd_s2_q;
      nwr_s1_q <= slot_nwr; nwr_s2_q <= nwr_s1_q; nwr_s3_q <= nwr_s2_q;
    end
  end

  // Mapper bank registers and the mode bit that gates the register window.
  always_ff @(posedge clk) begin
    if (slot_reset) begin
      for (int n = 0; n < 4; n++) bank_q[n] <= 8'(n);
      mode6_q <= 1'b0;
    end else if (wr_go && !w_win) begin
      if (a_s2_q[12:11] == 2'b10)
        bank_q[w_page] <= d_s2_q;
      else if ((w_page == 2'd3) && (a_s2_q[12:0] == 13'h1FFF))
        mode6_q <= d_s2_q[6];
    end
  end

  // Tone channel register file; unused bits are never stored.
  always_ff @(posedge clk) begin
    if (slot_reset) begin
      for (int c = 0; c < 12; c++) begin
        freq_q[c] <= '0;
        vol_q[c]  <= '0;
        en_q[c]   <= '0;
      end
    end else if (ch_wr) begin
      case (w_idx[1:0])
        2'd0:    freq_q[w_ch][7:0]  <= d_s2_q;
        2'd1:    freq_q[w_ch][11:8] <= d_s2_q[3:0];
        2'd2:    vol_q[w_ch]        <= d_s2_q[3:0];
        default: en_q[w_ch]         <= d_s2_q[1:0];
      endcase
    end
  end

  // Interval timers: private prescaler each, so a control write restarts
  // the tick phase. A same-cycle flag set overrides the status-read clear.
  always_ff @(posedge clk) begin
    if (slot_reset) begin
      for (int t = 0; t < 2; t++) begin
        tctl_q[t] <= '0;
        tcnt_q[t] <= '0;
        tpre_q[t] <= '0;
      end
      tflag_q <= '0;
    end else begin
      for (int t = 0; t < 2; t++) begin
        if (tstat_rd[t]) tflag_q[t] <= 1'b0;
        if (tctl_wr[t]) begin
          tctl_q[t]  <= d_s2_q;
          tcnt_q[t]  <= d_s2_q[5:0];
          tpre_q[t]  <= '0;
          tflag_q[t] <= 1'b0;
        end else if (tctl_q[t][7]) begin
          if (tpre_q[t] == PRE_LAST) begin
            tpre_q[t] <= '0;
            if (tcnt_q[t] == 6'd0) begin
              tflag_q[t] <= 1'b1;
              tcnt_q[t]  <= tctl_q[t][5:0];
              if (tctl_q[t][6]) tctl_q[t][7] <= 1'b0;
            end else begin
              tcnt_q[t] <= tcnt_q[t] - 6'd1;
            end
          end else begin
            tpre_q[t] <= tpre_q[t] + PW'(1);
          end
        end
      end
    end
  end

  // Tone generators: shared free-running tick, per-channel reload counter.
  always_ff @(posedge clk) begin
    if (slot_reset) begin
      tone_pre_q <= '0;
      sq_q       <= '0;
      for (int c = 0; c < 12; c++) tone_cnt_q[c] <= '0;
    end else begin
      tone_pre_q <= (tone_pre_q == PRE_LAST) ? '0 : tone_pre_q + PW'(1);
      if (tone_pre_q == PRE_LAST) begin
        for (int c = 0; c < 12; c++) begin
          if (freq_q[c] == 12'd0) begin
            sq_q[c]       <= 1'b0;
            tone_cnt_q[c] <= 12'd0;
          end else if (tone_cnt_q[c] == 12'd0) begin
            tone_cnt_q[c] <= freq_q[c];
            sq_q[c]       <= ~sq_q[c];
          end else begin
            tone_cnt_q[c] <= tone_cnt_q[c] - 12'd1;
          end
        end
      end
    end
  end

  // Mixer: 12 x 240 fits in 12 bits; mono averages the two sums.
  logic [11:0] sum_l, sum_r;
  logic [7:0]  contrib;
  logic [12:0] mono_sum;
  always_comb begin
    sum_l   = '0;
    sum_r   = '0;
    contrib = '0;
    for (int c = 0; c < 12; c++) begin
      contrib = sq_q[c] ? {vol_q[c], 4'b0} : 8'd0;
      if (en_q[c][0]) sum_l = sum_l + {4'h0, contrib};
      if (en_q[c][1]) sum_r = sum_r + {4'h0, contrib};
    end
    mono_sum = {1'b0, sum_l} + {1'b0, sum_r};
    left_d   = sw_mono ? mono_sum[12:1] : sum_l;
    right_d  = sw_mono ? mono_sum[12:1] : sum_r;
  end

  // Registered audio outputs.
  always_ff @(posedge clk) begin
    if (slot_reset) begin
      left_q  <= '0;
      right_q <= '0;
    end else begin
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign left_out  = left_q;
  assign right_out = right_q;

endmodule

// File: tb/tb_wts_for_cartridge.sv
// Directed + randomized bench for wts_for_cartridge. Open-collector and
// released bus lines are pulled up here, so "not driven" reads as all ones.
module tb_wts_for_cartridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        slot_reset = 1'b1;
  logic [14:0] slot_a = '0;
  logic        nsltsl = 1'b1, nmerq = 1'b1, nrd = 1'b1, nwr = 1'b1;
  logic        sw_mono = 1'b0;
  logic [7:0]  d_drv = '0;
  logic        d_oe = 1'b0;
  tri1 [7:0]   slot_d;
  tri1         slot_nint;
  wire         mem_ncs;
  wire [7:0]   mem_a;
  wire [11:0]  left_out, right_out;

  assign slot_d = d_oe ? d_drv : 8'hzz;

  wts_for_cartridge #(.TICK_DIV(16)) dut (
    .clk(clk), .slot_reset(slot_reset), .slot_nint(slot_nint),
    .slot_a(slot_a), .slot_d(slot_d), .slot_nsltsl(nsltsl),
    .slot_nmerq(nmerq), .slot_nrd(nrd), .slot_nwr(nwr),
    .sw_mono(sw_mono), .mem_ncs(mem_ncs), .mem_a(mem_a),
    .left_out(left_out), .right_out(right_out)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: channel register contents as the host should see them.
  logic [7:0] exp_ch [192];
  logic [7:0] exp_bank [4];

  function automatic void model_wr(int idx, logic [7:0] d);
    if (idx < 192) begin
      case (idx % 16)
        0: exp_ch[idx] = d;
        1: exp_ch[idx] = d & 8'h0F;
        2: exp_ch[idx] = d & 8'h0F;
        3: exp_ch[idx] = d & 8'h03;
        default: ;
      endcase
    end
  endfunction

  function automatic logic [7:0] model_rd(int idx);
    if (idx < 192 && (idx % 16) < 4) return exp_ch[idx];
    return 8'hFF;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(logic [15:0] addr, logic [7:0] data);
    @(posedge clk);
    slot_a = addr[14:0]; d_drv = data; d_oe = 1'b1; nsltsl = 1'b0; nmerq = 1'b0;
    repeat (3) @(posedge clk);
    nwr = 1'b0;
    repeat (4) @(posedge clk);
    nwr = 1'b1;
    repeat (3) @(posedge clk);
    nsltsl = 1'b1; nmerq = 1'b1; d_oe = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic bus_rd(logic [15:0] addr, output logic [7:0] data,
                        output logic ncs, output logic [7:0] ma);
    @(posedge clk);
    slot_a = addr[14:0]; nsltsl = 1'b0; nmerq = 1'b0;
    repeat (3) @(posedge clk);
    nrd = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    data = slot_d; ncs = mem_ncs; ma = mem_a;
    @(posedge clk);
    nrd = 1'b1;
    repeat (4) @(posedge clk);
    nsltsl = 1'b1; nmerq = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_nint_low(int maxc, output int t, output bit ok);
    ok = 1'b0; t = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (slot_nint === 1'b0) begin ok = 1'b1; t = cyc; break; end
    end
  endtask

  // Watch the mix for ncyc clocks: left must alternate 0 <-> lvl_l every
  // 32 clk and right must track it with lvl_r.
  task automatic watch_tone(string tag, int ncyc, logic [11:0] lvl_l, logic [11:0] lvl_r);
    logic [11:0] prev;
    int last, nchg, bad;
    @(negedge clk);
    prev = left_out; last = -1; nchg = 0; bad = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (!((left_out == 12'd0 && right_out == 12'd0) ||
            (left_out == lvl_l && right_out == lvl_r))) bad++;
      if (left_out !== prev) begin
        if (last >= 0) chk({tag, "_interval"}, cyc - last, 32);
        last = cyc; nchg++; prev = left_out;
      end
    end
    chk({tag, "_levels_bad"}, bad, 0);
    chk({tag, "_toggles_ge8"}, (nchg >= 8) ? 1 : 0, 1);
  endtask

  logic [7:0] rd, ma;
  logic ncs;
  int t1, t2, t3;
  bit ok;

  initial begin
    for (int i = 0; i < 192; i++) exp_ch[i] = 8'h00;
    for (int n = 0; n < 4; n++) exp_bank[n] = 8'(n);

    // Reset state
    repeat (4) @(posedge clk);
    slot_reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("nint_after_reset", slot_nint, 1'b1);
    chk("left_after_reset", left_out, 12'd0);
    bus_rd(16'h4000, rd, ncs, ma);
    chk("rst_4000_mema", ma, 8'h00);
    chk("rst_4000_ncs", ncs, 1'b0);
    chk("rst_4000_d_released", rd, 8'hFF);
    bus_rd(16'h6000, rd, ncs, ma); chk("rst_6000_mema", ma, 8'h01);
    bus_rd(16'h8000, rd, ncs, ma); chk("rst_8000_mema", ma, 8'h02);
    bus_rd(16'hA000, rd, ncs, ma); chk("rst_A000_mema", ma, 8'h03);

    // Enable the register window
    bus_wr(16'hB000, 8'h80); exp_bank[3] = 8'h80;
    bus_wr(16'hBFFF, 8'h40);

    // Channel setup {2i, 0, 15, 3}
    for (int i = 0; i < 12; i++) begin
      bus_wr(16'hAE00 + 16'(16 * i) + 16'd0, 8'(2 * i)); model_wr(16 * i + 0, 8'(2 * i));
      bus_wr(16'hAE00 + 16'(16 * i) + 16'd1, 8'h00);     model_wr(16 * i + 1, 8'h00);
      bus_wr(16'hAE00 + 16'(16 * i) + 16'd2, 8'h0F);     model_wr(16 * i + 2, 8'h0F);
      bus_wr(16'hAE00 + 16'(16 * i) + 16'd3, 8'h03);     model_wr(16 * i + 3, 8'h03);
    end
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 4; k++) begin
        bus_rd(16'hAE00 + 16'(16 * i + k), rd, ncs, ma);
        chk($sformatf("ch%0d_reg%0d", i, k), rd, model_rd(16 * i + k));
      end
    end
    bus_rd(16'hAE00, rd, ncs, ma); chk("win_read_ncs_high", ncs, 1'b1);
    bus_rd(16'hAEF1, rd, ncs, ma); chk("stat1_idle", rd, 8'h80);
    bus_rd(16'hAEF3, rd, ncs, ma); chk("stat2_idle", rd, 8'h80);
    bus_rd(16'hAEF0, rd, ncs, ma); chk("ctl1_reset", rd, 8'h00);
    bus_rd(16'hAEC5, rd, ncs, ma); chk("unmapped_C5", rd, 8'hFF);

    // Randomized register traffic through mirrored addresses
    for (int n = 0; n < 30; n++) begin
      int widx, ridx;
      logic [7:0] wd;
      logic [15:0] wa;
      widx = $urandom_range(0, 11) * 16 + $urandom_range(0, 7);
      wd   = 8'($urandom_range(0, 255));
      wa   = 16'hA800 | 16'($urandom_range(0, 7) << 8) | 16'(widx);
      bus_wr(wa, wd); model_wr(widx, wd);
      bus_rd(16'hA800 | 16'($urandom_range(0, 7) << 8) | 16'(widx), rd, ncs, ma);
      chk($sformatf("rand_wr_rb_%0h", widx), rd, model_rd(widx));
      ridx = $urandom_range(0, 8'hEF);
      bus_rd(16'hAF00 | 16'(ridx), rd, ncs, ma);
      chk($sformatf("rand_rd_%0h", ridx), rd, model_rd(ridx));
    end

    // One-shot timers, period 0
    bus_wr(16'hAEF0, 8'hC0);
    bus_wr(16'hAEF2, 8'hC0);
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("nint_both_pending", slot_nint, 1'b0);
    bus_rd(16'hAEF1, rd, ncs, ma); chk("stat1_pending", rd, 8'h00);
    @(negedge clk); chk("nint_t2_still", slot_nint, 1'b0);
    bus_rd(16'hAEF3, rd, ncs, ma); chk("stat2_pending", rd, 8'h00);
    @(negedge clk); chk("nint_released", slot_nint, 1'b1);
    bus_rd(16'hAEF1, rd, ncs, ma); chk("stat1_reread", rd, 8'h80);
    bus_rd(16'hAEF3, rd, ncs, ma); chk("stat2_reread", rd, 8'h80);
    bus_rd(16'hAEF0, rd, ncs, ma); chk("ctl1_oneshot_en_clr", rd, 8'h40);

    // Periodic timer, period 3 -> every 4 ticks = 64 clk
    bus_wr(16'hAEF0, 8'h83);
    wait_nint_low(200, t1, ok); chk("per_flag1_seen", ok, 1'b1);
    bus_rd(16'hAEF1, rd, ncs, ma); chk("per_stat_a", rd, 8'h00);
    wait_nint_low(200, t2, ok); chk("per_flag2_seen", ok, 1'b1);
    chk("per_interval_a", t2 - t1, 64);
    bus_rd(16'hAEF1, rd, ncs, ma); chk("per_stat_b", rd, 8'h00);
    wait_nint_low(200, t3, ok); chk("per_flag3_seen", ok, 1'b1);
    chk("per_interval_b", t3 - t2, 64);
    bus_rd(16'hAEF0, rd, ncs, ma); chk("per_ctl_en_kept", rd, 8'h83);
    bus_wr(16'hAEF0, 8'h00);
    @(negedge clk); chk("per_stop_nint", slot_nint, 1'b1);

    // Tone: only ch0 audible
    for (int i = 0; i < 12; i++) bus_wr(16'hAE03 + 16'(16 * i), 8'h00);
    bus_wr(16'hAE00, 8'h01);
    bus_wr(16'hAE01, 8'h00);
    bus_wr(16'hAE02, 8'h0F);
    bus_wr(16'hAE03, 8'h03);
    watch_tone("tone_stereo", 400, 12'd240, 12'd240);
    sw_mono = 1'b1;
    watch_tone("tone_mono", 400, 12'd240, 12'd240);
    bus_wr(16'hAE03, 8'h01);
    watch_tone("tone_mono_left_only", 400, 12'd120, 12'd120);
    sw_mono = 1'b0;
    watch_tone("tone_left_only", 400, 12'd240, 12'd0);

    // Mapper
    bus_wr(16'h5000, 8'h05); exp_bank[0] = 8'h05;
    bus_rd(16'h4000, rd, ncs, ma);
    chk("map_4000_ncs", ncs, 1'b0);
    chk("map_4000_mema", ma, 8'h05);
    for (int n = 0; n < 8; n++) begin
      int p;
      logic [7:0] b;
      logic [15:0] wa;
      p = $urandom_range(0, 2);
      b = 8'($urandom_range(0, 255));
      wa = 16'h4000 + 16'(p * 16'h2000) + 16'h1000;
      bus_wr(wa, b); exp_bank[p] = b;
      bus_rd(16'h4000 + 16'(p * 16'h2000) + 16'(16'($urandom_range(0, 16'h1FFF))), rd, ncs, ma);
      chk($sformatf("map_rand_page%0d", p), ma, exp_bank[p]);
    end

    // Mode 0: window closed, AE00h becomes memory
    bus_wr(16'hBFFF, 8'h00);
    bus_rd(16'hAE00, rd, ncs, ma);
    chk("mode0_ncs", ncs, 1'b0);
    chk("mode0_mema", ma, exp_bank[3]);
    chk("mode0_d_released", rd, 8'hFF);

    // Reset in the middle of a register read with a flag pending
    bus_wr(16'hBFFF, 8'h40);
    bus_wr(16'hAEF2, 8'hC0);
    repeat (30) @(posedge clk);
    @(negedge clk); chk("pre_rst_nint", slot_nint, 1'b0);
    @(posedge clk);
    slot_a = 15'h2E00; nsltsl = 1'b0; nmerq = 1'b0;
    repeat (3) @(posedge clk);
    nrd = 1'b0;
    @(negedge clk); chk("mid_read_data", slot_d, 8'h01);
    slot_reset = 1'b1;
    #1;
    chk("rst_d_released", slot_d, 8'hFF);
    chk("rst_nint_released", slot_nint, 1'b1);
    repeat (3) @(posedge clk);
    nrd = 1'b1; nsltsl = 1'b1; nmerq = 1'b1;
    slot_reset = 1'b0;
    repeat (3) @(posedge clk);

    // Reset while a write is in flight: the write must be lost
    bus_wr(16'hB000, 8'h80);
    @(posedge clk);
    slot_a = 15'h3FFF; d_drv = 8'h40; d_oe = 1'b1; nsltsl = 1'b0; nmerq = 1'b0;
    repeat (3) @(posedge clk);
    nwr = 1'b0;
    @(posedge clk);
    slot_reset = 1'b1; nwr = 1'b1; nsltsl = 1'b1; nmerq = 1'b1; d_oe = 1'b0;
    repeat (3) @(posedge clk);
    slot_reset = 1'b0;
    repeat (4) @(posedge clk);
    bus_rd(16'hA000, rd, ncs, ma); chk("post_rst_bank3", ma, 8'h03);
    bus_rd(16'hAE00, rd, ncs, ma); chk("post_rst_no_window", ncs, 1'b0);
    @(negedge clk); chk("post_rst_nint", slot_nint, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
